// File: rtl/ring_worker_multi.sv
// ---------------------------------------------------------------------------
// ring_worker_multi
//   Worker clocked directly by the ring oscillator under test. It provides a
//   free-running divider tap bus, a mode-selectable event counter with a
//   programmable terminal count, and a coarse upper-bit readout that a slow
//   external sampler can read.
//
// Ports
//   clk      : oscillator clock, the only clock domain
//   reset_n  : asynchronous active-low reset (release is synchronised inside)
//   mode     : count mode, may change asynchronously to clk
//                00 saturate up, 01 wrap up, 10 prescaled saturate, 11 freeze
//   oscdiv   : {div_cnt, clk}, free-running binary divider taps
//   raw_data : event counter, never exceeds LIMIT
//   computed : upper OUT_W bits of raw_data
//   done     : terminal count reached in modes 00/10
//   wrapped  : sticky, counter wrapped LIMIT -> 0 in mode 01
// ---------------------------------------------------------------------------
module ring_worker_multi #(
  parameter int CNT_W       = 12,
  parameter int LIMIT       = 3000,
  parameter int DIV_W       = 3,
  parameter int OUT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  output logic [DIV_W:0]   oscdiv,
  output logic [CNT_W-1:0] raw_data,
  output logic [OUT_W-1:0] computed,
  output logic             done,
  output logic             wrapped
);

  localparam logic [1:0]       MODE_SAT  = 2'b00;
  localparam logic [1:0]       MODE_WRAP = 2'b01;
  localparam logic [1:0]       MODE_PRE  = 2'b10;
  localparam logic [1:0]       MODE_FRZ  = 2'b11;
  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(LIMIT);
  localparam logic [DIV_W-1:0] PRE_MAX   = {DIV_W{1'b1}};

  logic [SYNC_STAGES-1:0]      rst_sync_r;
  logic [SYNC_STAGES-1:0][1:0] mode_pipe_r;
  logic [DIV_W-1:0]            div_cnt_r;
  logic [DIV_W-1:0]            pre_cnt_r;
  logic [CNT_W-1:0]            raw_data_r;
  logic                        done_r;
  logic                        wrapped_r;

  logic                        run_s;
  logic [1:0]                  mode_s;
  logic [1:0]                  mode_next_s;
  logic [CNT_W-1:0]            raw_next_s;
  logic [DIV_W-1:0]            pre_next_s;
  logic                        done_next_s;
  logic                        wrapped_next_s;

  // The run flag is the tail of the release synchroniser; all counters are
  // held cleared until it rises.
  assign run_s       = rst_sync_r[SYNC_STAGES-1];
  // mode_next_s is the value mode_s will take on the coming edge, which is
  // what done has to be qualified with.
  assign mode_s      = mode_pipe_r[SYNC_STAGES-1];
  assign mode_next_s = mode_pipe_r[SYNC_STAGES-2];

  // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Mode synchroniser; shares the release timing with the reset chain so that
  // mode_s already carries the live mode on the first counting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_pipe_r <= {SYNC_STAGES{2'b00}};
    end else begin
      mode_pipe_r <= {mode_pipe_r[SYNC_STAGES-2:0], mode};
    end
  end

  // Next-state rules for the event counter, prescaler and status flags.
  always_comb begin
    raw_next_s     = raw_data_r;
    pre_next_s     = {DIV_W{1'b0}};
    wrapped_next_s = wrapped_r;
    case (mode_s)
      MODE_SAT: begin
        if (raw_data_r < LIMIT_C) begin
          raw_next_s = raw_data_r + 1'b1;
        end else begin
          raw_next_s = raw_data_r;
        end
      end
      MODE_WRAP: begin
        if (raw_data_r == LIMIT_C) begin
          raw_next_s     = {CNT_W{1'b0}};
          wrapped_next_s = 1'b1;
        end else begin
          raw_next_s = raw_data_r + 1'b1;
        end
      end
      MODE_PRE: begin
        // Prescaler idles at zero outside this mode, so entering it always
        // starts a full 2^DIV_W period.
        if (pre_cnt_r == PRE_MAX) begin
          pre_next_s = {DIV_W{1'b0}};
          if (raw_data_r < LIMIT_C) begin
            raw_next_s = raw_data_r + 1'b1;
          end else begin
            raw_next_s = raw_data_r;
          end
        end else begin
          pre_next_s = pre_cnt_r + 1'b1;
        end
      end
      MODE_FRZ: begin
        raw_next_s = raw_data_r;
      end
      default: begin
        raw_next_s = raw_data_r;
      end
    endcase

    if (mode_next_s == MODE_FRZ) begin
      done_next_s = done_r;
    end else begin
      done_next_s = (raw_next_s == LIMIT_C) && (mode_next_s[0] == 1'b0);
    end
  end

  // Counter, divider and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r  <= {DIV_W{1'b0}};
      pre_cnt_r  <= {DIV_W{1'b0}};
      raw_data_r <= {CNT_W{1'b0}};
      done_r     <= 1'b0;
      wrapped_r  <= 1'b0;
    end else if (run_s) begin
      div_cnt_r  <= div_cnt_r + 1'b1;
      pre_cnt_r  <= pre_next_s;
      raw_data_r <= raw_next_s;
      done_r     <= done_next_s;
      wrapped_r  <= wrapped_next_s;
    end else begin
      div_cnt_r  <= {DIV_W{1'b0}};
      pre_cnt_r  <= {DIV_W{1'b0}};
      raw_data_r <= {CNT_W{1'b0}};
      done_r     <= 1'b0;
      wrapped_r  <= 1'b0;
    end
  end

  // oscdiv[0] is the raw oscillator; everything else is registered.
  assign oscdiv   = {div_cnt_r, clk};
  assign raw_data = raw_data_r;
  assign computed = raw_data_r[CNT_W-1 -: OUT_W];
  assign done     = done_r;
  assign wrapped  = wrapped_r;

endmodule

// File: tb/tb_ring_worker_multi.sv
// ---------------------------------------------------------------------------
// tb_ring_worker_multi
//   Two instances share clock, reset and mode: a default-sized one (LIMIT
//   3000, two sync stages) and a small one whose LIMIT is 2^CNT_W-1 and which
//   uses three sync stages. An edge-level reference model pushes the expected
//   state after every rising edge into a queue; a monitor on the falling edge
//   pops and compares. Directed checks pin the headline timing points.
// ---------------------------------------------------------------------------
module tb_ring_worker_multi;

  localparam int B_CNT_W = 12, B_LIMIT = 3000, B_DIV_W = 3, B_OUT_W = 6, B_SS = 2;
  localparam int S_CNT_W = 4,  S_LIMIT = 15,   S_DIV_W = 3, S_OUT_W = 2, S_SS = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [B_DIV_W:0]   b_oscdiv;
  logic [B_CNT_W-1:0] b_raw;
  logic [B_OUT_W-1:0] b_comp;
  logic               b_done, b_wrapped;
  logic [S_DIV_W:0]   s_oscdiv;
  logic [S_CNT_W-1:0] s_raw;
  logic [S_OUT_W-1:0] s_comp;
  logic               s_done, s_wrapped;

  ring_worker_multi #(.CNT_W(B_CNT_W), .LIMIT(B_LIMIT), .DIV_W(B_DIV_W),
                      .OUT_W(B_OUT_W), .SYNC_STAGES(B_SS)) u_big (
    .clk(clk), .reset_n(reset_n), .mode(mode), .oscdiv(b_oscdiv),
    .raw_data(b_raw), .computed(b_comp), .done(b_done), .wrapped(b_wrapped));

  ring_worker_multi #(.CNT_W(S_CNT_W), .LIMIT(S_LIMIT), .DIV_W(S_DIV_W),
                      .OUT_W(S_OUT_W), .SYNC_STAGES(S_SS)) u_small (
    .clk(clk), .reset_n(reset_n), .mode(mode), .oscdiv(s_oscdiv),
    .raw_data(s_raw), .computed(s_comp), .done(s_done), .wrapped(s_wrapped));

  always #5 clk = ~clk;

  typedef struct {
    int raw;
    int pre;
    int div;
    bit done;
    bit wrapped;
  } mdl_t;

  typedef struct {
    mdl_t b;
    mdl_t s;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  mdl_t mb = '{default: 0};
  mdl_t ms = '{default: 0};
  int   edges = 0;
  int   mode_hist[$];
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mode seen at rising edge k after release (edge 1 is the first); before
  // any sample exists the synchroniser reads as mode 00.
  function automatic int mode_at(input int k);
    if (k < 1) return 0;
    return mode_hist[k-1];
  endfunction

  // One counting edge. cur is the synchronised mode governing this edge,
  // nxt the synchronised mode visible after it.
  function automatic mdl_t step(input mdl_t st, input int cur, input int nxt,
                                input int limit, input int div_w);
    mdl_t r = st;
    int period = 1 << div_w;
    if (cur == 2) begin
      if (r.pre == period - 1) begin
        r.pre = 0;
        if (r.raw < limit) r.raw++;
      end else begin
        r.pre++;
      end
    end else begin
      r.pre = 0;
      if (cur == 0) begin
        if (r.raw < limit) r.raw++;
      end else if (cur == 1) begin
        if (r.raw == limit) begin
          r.raw = 0;
          r.wrapped = 1'b1;
        end else begin
          r.raw++;
        end
      end
    end
    r.div = (r.div + 1) % period;
    if (nxt != 3) r.done = (r.raw == limit) && (nxt != 1);
    return r;
  endfunction

  // Reference model: advance on each rising edge and queue the expectation.
  always @(posedge clk) begin
    exp_t e;
    if (reset_n) begin
      edges++;
      mode_hist.push_back(int'(mode));
      if (edges > B_SS) mb = step(mb, mode_at(edges - B_SS), mode_at(edges - B_SS + 1), B_LIMIT, B_DIV_W);
      if (edges > S_SS) ms = step(ms, mode_at(edges - S_SS), mode_at(edges - S_SS + 1), S_LIMIT, S_DIV_W);
    end
    e.b = mb;
    e.s = ms;
    exp_q.push_back(e);
  end

  // Reset assertion clears the model at once and discards stale expectations.
  always @(negedge reset_n) begin
    mb = '{default: 0};
    ms = '{default: 0};
    edges = 0;
    mode_hist.delete();
    exp_q.delete();
  end

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("b_raw",     int'(b_raw),               e.b.raw);
      chk("b_div",     int'(b_oscdiv[B_DIV_W:1]), e.b.div);
      chk("b_osc0",    int'(b_oscdiv[0]),         0);
      chk("b_comp",    int'(b_comp),              e.b.raw >> (B_CNT_W - B_OUT_W));
      chk("b_done",    int'(b_done),              int'(e.b.done));
      chk("b_wrapped", int'(b_wrapped),           int'(e.b.wrapped));
      chk("s_raw",     int'(s_raw),               e.s.raw);
      chk("s_div",     int'(s_oscdiv[S_DIV_W:1]), e.s.div);
      chk("s_comp",    int'(s_comp),              e.s.raw >> (S_CNT_W - S_OUT_W));
      chk("s_done",    int'(s_done),              int'(e.s.done));
      chk("s_wrapped", int'(s_wrapped),           int'(e.s.wrapped));
    end
  end

  // Advance n rising edges and land 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset_n = 1'b0;
    mode = m;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    int d0;
    int found;

    // Scenario 1: release in SAT_UP, terminal count at edge 3002.
    tick(3);
    chk("rst_b_raw", int'(b_raw), 0);
    chk("rst_b_done", int'(b_done), 0);
    reset_n = 1'b1;
    tick(2);
    chk("s1_edge2_raw", int'(b_raw), 0);
    tick(1);
    chk("s1_edge3_raw", int'(b_raw), 1);
    chk("s1_edge3_div", int'(b_oscdiv[B_DIV_W:1]), 1);
    chk("s1_osc0_high", int'(b_oscdiv[0]), 1);
    chk("s1_small_edge3", int'(s_raw), 0);
    tick(2998);
    chk("s1_edge3001_raw", int'(b_raw), 2999);
    chk("s1_edge3001_done", int'(b_done), 0);
    tick(1);
    chk("s1_edge3002_raw", int'(b_raw), 3000);
    chk("s1_edge3002_done", int'(b_done), 1);
    chk("s1_comp", int'(b_comp), 46);
    tick(100);
    chk("s1_hold_raw", int'(b_raw), 3000);
    chk("s1_hold_done", int'(b_done), 1);

    // Scenario 4: freeze at raw_data=100, then resume.
    do_reset(2'b00);
    tick(102);
    chk("s4_at100", int'(b_raw), 100);
    mode = 2'b11;
    tick(20);
    chk("s4_frozen_range", int'(b_raw >= 100 && b_raw <= 100 + B_SS + 1), 1);
    d0 = int'(b_oscdiv[B_DIV_W:1]);
    tick(5);
    chk("s4_div_runs", (int'(b_oscdiv[B_DIV_W:1]) - d0 + 8) % 8, 5);
    mode = 2'b00;
    tick(30);

    // Scenario 2: WRAP_UP, big wraps once, small (LIMIT=2^CNT_W-1) many times.
    do_reset(2'b01);
    tick(3002);
    chk("s2_pre_wrap_raw", int'(b_raw), 3000);
    chk("s2_pre_wrap_flag", int'(b_wrapped), 0);
    tick(1);
    chk("s2_wrap_raw", int'(b_raw), 0);
    chk("s2_wrap_flag", int'(b_wrapped), 1);
    chk("s2_wrap_done", int'(b_done), 0);

    // Scenario 5: asynchronous reset mid-count, between clock edges.
    tick(1234);
    chk("s5_raw", int'(b_raw), 1234);
    reset_n = 1'b0;
    #1;
    chk("s5_b_raw0", int'(b_raw), 0);
    chk("s5_b_div0", int'(b_oscdiv[B_DIV_W:1]), 0);
    chk("s5_b_comp0", int'(b_comp), 0);
    chk("s5_b_wrapped0", int'(b_wrapped), 0);
    chk("s5_b_done0", int'(b_done), 0);
    chk("s5_s_raw0", int'(s_raw), 0);
    chk("s5_s_wrapped0", int'(s_wrapped), 0);
    tick(2);
    reset_n = 1'b1;
    mode = 2'b00;
    tick(3);
    chk("s5_restart_raw", int'(b_raw), 1);

    // Scenario 6: leave WRAP_UP so mode_s reaches 00 as small hits LIMIT.
    mode = 2'b01;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (i >= 5 && int'(s_raw) == S_LIMIT - S_SS) begin
        found = 1;
        break;
      end
    end
    chk("s6_wait", found, 1);
    mode = 2'b00;
    tick(S_SS);
    chk("s6_done", int'(s_done), 1);
    chk("s6_raw", int'(s_raw), S_LIMIT);
    tick(10);
    chk("s6_hold_raw", int'(s_raw), S_LIMIT);
    chk("s6_hold_done", int'(s_done), 1);

    // Scenario 3: SAT_PRESCALE, one increment per 8 edges.
    do_reset(2'b10);
    tick(33);
    chk("s3_edge33_raw", int'(b_raw), 3);
    tick(1);
    chk("s3_edge34_raw", int'(b_raw), 4);
    tick(100);
    chk("s3_small_raw", int'(s_raw), S_LIMIT);
    chk("s3_small_done", int'(s_done), 1);

    // Randomised mode changes with occasional reset pulses.
    for (int i = 0; i < 150; i++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
      end
      tick(int'($urandom_range(1, 30)));
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_worker_multi.md
Name: ring_worker_multi

Overview:
- Parametrised next-generation ring-oscillator worker, clocked directly by the oscillator under test.
- Provides a free-running divider tap bus, a mode-selectable event counter with a programmable limit, and a coarse upper-bit readout for slow external sampling.
- Adds the following over the previous worker:
  - Wrap, prescaled and freeze modes.
  - Done and wrapped status flags.
  - Synchronised mode input.
  - Asynchronous-assert / synchronous-release reset.

Parameters:
- CNT_W, 12: width of raw_data counter.
- LIMIT, 3000: terminal count. Must satisfy 1 <= LIMIT <= 2^CNT_W-1.
- DIV_W, 3: width of divider counter. oscdiv is DIV_W+1 bits.
- OUT_W, 6: width of computed. Must satisfy OUT_W <= CNT_W.
- SYNC_STAGES, 2: flop depth of the reset-release and mode synchronisers. Must be >= 2.

Ports:
- clk, in, 1: oscillator clock, sole clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- mode, in, 2: count mode; may change asynchronously to clk.
- oscdiv, out, DIV_W+1: {div_cnt, clk}; div_cnt is a free-running binary counter.
- raw_data, out, CNT_W: event counter.
- computed, out, OUT_W: raw_data[CNT_W-1 -: OUT_W].
- done, out, 1: registered; terminal count reached (modes 00/10).
- wrapped, out, 1: registered, sticky; counter wrapped in mode 01.

Behaviour:
- Reset, assertion:
  - reset_n low asynchronously clears div_cnt, raw_data, prescaler, done, wrapped, the mode synchroniser, and the internal run flag.
  - oscdiv[0] still follows clk.
- Reset, release:
  - Internal rst_sync deasserts after SYNC_STAGES rising clk edges with reset_n high.
  - div_cnt, prescaler and raw_data begin updating on the following edge.
  - With SYNC_STAGES=2: raw_data=1 and div_cnt=1 after the 3rd rising edge following reset_n rising.
  - Re-assertion mid-operation aborts immediately to reset state in any mode.
- div_cnt:
  - Increments every clk, wraps 2^DIV_W-1 -> 0, independent of mode.
- Mode synchronisation:
  - mode passes through SYNC_STAGES flops to give mode_s.
  - All mode decisions use mode_s, so a change takes effect SYNC_STAGES edges after it is stable.
  - Internal reset also clears mode_s to 00.
- Mode 00, SAT_UP:
  - raw_data increments each clk while < LIMIT, then holds at LIMIT.
- Mode 01, WRAP_UP:
  - raw_data increments each clk; LIMIT -> 0 on the next edge.
  - wrapped sets on that same edge and stays set until reset.
- Mode 10, SAT_PRESCALE:
  - 2^DIV_W-clk prescaler (separate from div_cnt, cleared when mode_s enters 10).
  - raw_data increments once per prescaler terminal (every 2^DIV_W clks) while < LIMIT, then holds.
- Mode 11, FREEZE:
  - raw_data, done and wrapped hold.
  - div_cnt keeps running.
- done:
  - Registered; equals (next raw_data == LIMIT) AND (next mode_s is 00 or 10).
  - Asserts on the same edge raw_data reaches LIMIT.
  - In mode 01 done=0; in mode 11 done holds its last value.
- Mode changes mid-count:
  - raw_data is never reloaded; counting resumes from the current value under the new rule.
  - Switching 01 -> 00 with raw_data == LIMIT gives done=1 within one edge of mode_s changing.
- Width/arithmetic:
  - Unsigned. No overflow possible, since raw_data never exceeds LIMIT.
  - LIMIT = 2^CNT_W-1 must wrap cleanly to 0 in mode 01.
- Timing:
  - All outputs are registered except oscdiv[0] (= clk).
  - computed is a pure bit-slice of registered raw_data.

Test Plan:
1. Reset release, mode=00, LIMIT=3000:
   - raw_data=1 on 3rd edge after reset_n rise.
   - raw_data=3000 and done=1 on edge 3002.
   - raw_data stays 3000 for 100 more edges.
   - computed=46 (3000>>6).
2. mode=01, LIMIT=5, CNT_W=4:
   - raw_data sequence 1,2,3,4,5,0,1.
   - wrapped rises on the edge raw_data goes 5->0 and stays 1.
   - done stays 0.
3. mode=10, DIV_W=3, LIMIT=4:
   - raw_data increments every 8 edges, reaching 4 at edge ~32 after release.
   - done=1 there, then holds.
4. Freeze mid-count:
   - mode=00, switch to 11 at raw_data=100.
   - raw_data stays 100+k (k <= SYNC_STAGES+1 in-flight increments) while oscdiv keeps counting.
   - Back to 00: resumes from the frozen value.
5. Async reset mid-count:
   - Drop reset_n between clk edges at raw_data=1234, wrapped=1.
   - All outputs 0 immediately, with no clk edge required.
   - Restart timing as in scenario 1.
6. 01 -> 00 at raw_data == LIMIT:
   - done=1 within SYNC_STAGES+1 edges.
   - raw_data holds at LIMIT with no wrap.
